raster_ctrl: RTL and testbench

RASTER_CTRL -- requirements
Module: raster_ctrl

---
 rtl/raster_ctrl.sv | 216 +++++++++++++++++++++
 tb/tb_raster_ctrl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/raster_ctrl.sv
// -----------------------------------------------------------------------------
// raster_ctrl
// Raster-scan controller for a KERNEL_P x KERNEL_P sliding-window pipeline.
// Counts incoming pixels of one frame, drives the line-buffer shift enable and
// publishes one registered window descriptor (centre coordinates, end-of-line
// and end-of-frame flags) per pixel that completes a full window.
//
// Ports
//   clk_i, rst_i        : rising-edge clock, synchronous active-high reset
//   start_i             : arms one frame (sampled only while idle)
//   valid_i / ready_o   : upstream pixel handshake
//   lb_shift_o          : line-buffer / window shift enable (= pixel accept)
//   col_o, row_o        : coordinates of the next pixel to be accepted
//   valid_o / ready_i   : downstream window handshake
//   ctr_col_o/ctr_row_o : window-centre coordinates, qualified by valid_o
//   eol_o, eof_o        : window taken at last column / last pixel of frame
//   busy_o              : controller is not idle
//   frame_done_o        : one-cycle pulse when a frame has fully drained
// -----------------------------------------------------------------------------
module raster_ctrl #(
   parameter int WIDTH_P  = 640,
   parameter int HEIGHT_P = 480,
   parameter int KERNEL_P = 3,
   parameter int CNT_W_P  = 16
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               start_i,
   input  logic               valid_i,
   output logic               ready_o,
   output logic               lb_shift_o,
   output logic [CNT_W_P-1:0] col_o,
   output logic [CNT_W_P-1:0] row_o,
   output logic               valid_o,
   input  logic               ready_i,
   output logic [CNT_W_P-1:0] ctr_col_o,
   output logic [CNT_W_P-1:0] ctr_row_o,
   output logic               eol_o,
   output logic               eof_o,
   output logic               busy_o,
   output logic               frame_done_o
);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_FILL   = 2'd1;
   localparam logic [1:0] ST_STREAM = 2'd2;
   localparam logic [1:0] ST_DONE   = 2'd3;

   localparam logic [CNT_W_P-1:0] COL_LAST = CNT_W_P'(WIDTH_P - 1);
   localparam logic [CNT_W_P-1:0] ROW_LAST = CNT_W_P'(HEIGHT_P - 1);
   localparam logic [CNT_W_P-1:0] K_M1     = CNT_W_P'(KERNEL_P - 1);
   localparam logic [CNT_W_P-1:0] K_M2     = CNT_W_P'(KERNEL_P - 2);
   localparam logic [CNT_W_P-1:0] K_HALF   = CNT_W_P'(KERNEL_P / 2);
   localparam logic [CNT_W_P-1:0] CNT_ZERO = {CNT_W_P{1'b0}};
   localparam logic [CNT_W_P-1:0] CNT_ONE  = CNT_W_P'(1);

   logic [1:0]         state_q,   state_d;
   logic [CNT_W_P-1:0] col_q,     col_d;
   logic [CNT_W_P-1:0] row_q,     row_d;
   logic               valid_q,   valid_d;
   logic [CNT_W_P-1:0] ctr_col_q, ctr_col_d;
   logic [CNT_W_P-1:0] ctr_row_q, ctr_row_d;
   logic               eol_q,     eol_d;
   logic               eof_q,     eof_d;
   logic               done_q,    done_d;

   logic               running_s;
   logic               ready_s;
   logic               accept_s;
   logic               at_eol_s;
   logic               at_eof_s;
   logic               qualify_s;
   logic [CNT_W_P-1:0] col_adv_s;
   logic [CNT_W_P-1:0] row_adv_s;

   // Handshake decode; ready is forced low in the reset cycle so no pixel
   // is consumed while the controller is being cleared.
   always_comb begin
      running_s = (state_q == ST_FILL) || (state_q == ST_STREAM);
      ready_s   = running_s && (!valid_q || ready_i) && !rst_i;
      accept_s  = valid_i && ready_s;
      at_eol_s  = (col_q == COL_LAST);
      at_eof_s  = at_eol_s && (row_q == ROW_LAST);
      // A pixel completes a window once KERNEL_P-1 full lines and columns precede it.
      qualify_s = accept_s && (row_q >= K_M1) && (col_q >= K_M1);
   end

   // Raster advance of the pixel coordinates (column wraps into the next row).
   always_comb begin
      if (at_eol_s) begin
         col_adv_s = CNT_ZERO;
         row_adv_s = row_q + CNT_ONE;
      end else begin
         col_adv_s = col_q + CNT_ONE;
         row_adv_s = row_q;
      end
   end

   // Frame state machine and coordinate counters.
   always_comb begin
      state_d = state_q;
      col_d   = col_q;
      row_d   = row_q;
      done_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               state_d = ST_FILL;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_FILL: begin
            if (accept_s) begin
               col_d = col_adv_s;
               row_d = row_adv_s;
               if (at_eol_s && (row_q == K_M2)) begin
                  state_d = ST_STREAM;
               end else begin
                  state_d = ST_FILL;
               end
            end else begin
               state_d = ST_FILL;
            end
         end
         ST_STREAM: begin
            if (accept_s) begin
               if (at_eof_s) begin
                  // Counters stay parked on the last pixel; no wrap past the frame.
                  state_d = ST_DONE;
               end else begin
                  col_d = col_adv_s;
                  row_d = row_adv_s;
               end
            end else begin
               state_d = ST_STREAM;
            end
         end
         ST_DONE: begin
            // Wait for the final window to be taken before reporting completion.
            if (!valid_q) begin
               state_d = ST_IDLE;
               col_d   = CNT_ZERO;
               row_d   = CNT_ZERO;
               done_d  = 1'b1;
            end else begin
               state_d = ST_DONE;
            end
         end
         default: begin
            state_d = ST_IDLE;
            col_d   = CNT_ZERO;
            row_d   = CNT_ZERO;
         end
      endcase
   end

   // Downstream window register: load on a qualifying accept, drop when taken,
   // otherwise hold every field stable.
   always_comb begin
      valid_d   = valid_q;
      ctr_col_d = ctr_col_q;
      ctr_row_d = ctr_row_q;
      eol_d     = eol_q;
      eof_d     = eof_q;
      if (qualify_s) begin
         valid_d   = 1'b1;
         ctr_col_d = col_q - K_HALF;
         ctr_row_d = row_q - K_HALF;
         eol_d     = at_eol_s;
         eof_d     = at_eof_s;
      end else if (ready_i) begin
         valid_d = 1'b0;
      end else begin
         valid_d = valid_q;
      end
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= ST_IDLE;
         col_q     <= CNT_ZERO;
         row_q     <= CNT_ZERO;
         valid_q   <= 1'b0;
         ctr_col_q <= CNT_ZERO;
         ctr_row_q <= CNT_ZERO;
         eol_q     <= 1'b0;
         eof_q     <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         col_q     <= col_d;
         row_q     <= row_d;
         valid_q   <= valid_d;
         ctr_col_q <= ctr_col_d;
         ctr_row_q <= ctr_row_d;
         eol_q     <= eol_d;
         eof_q     <= eof_d;
         done_q    <= done_d;
      end
   end

   assign ready_o      = ready_s;
   assign lb_shift_o   = accept_s;
   assign col_o        = col_q;
   assign row_o        = row_q;
   assign valid_o      = valid_q;
   assign ctr_col_o    = ctr_col_q;
   assign ctr_row_o    = ctr_row_q;
   assign eol_o        = eol_q;
   assign eof_o        = eof_q;
   assign busy_o       = (state_q != ST_IDLE);
   assign frame_done_o = done_q;

endmodule

// File: tb/tb_raster_ctrl.sv
// -----------------------------------------------------------------------------
// tb_raster_ctrl
// Self-checking bench for raster_ctrl (4x3 frame, 3x3 window). The reference
// model tracks the frame as a count of accepted pixels and derives coordinates
// and expected windows from raster arithmetic; windows are scoreboarded in a
// queue and compared when the downstream side takes them.
// -----------------------------------------------------------------------------
module tb_raster_ctrl;

   localparam int W    = 4;
   localparam int H    = 3;
   localparam int K    = 3;
   localparam int CW   = 16;
   localparam int NPIX = W * H;

   logic          clk = 1'b0;
   logic          rst_i = 1'b1;
   logic          start_i = 1'b0;
   logic          valid_i = 1'b0;
   logic          ready_i = 1'b1;
   logic          ready_o, lb_shift_o, valid_o, eol_o, eof_o, busy_o, frame_done_o;
   logic [CW-1:0] col_o, row_o, ctr_col_o, ctr_row_o;

   raster_ctrl #(.WIDTH_P(W), .HEIGHT_P(H), .KERNEL_P(K), .CNT_W_P(CW)) dut (
      .clk_i       (clk),
      .rst_i       (rst_i),
      .start_i     (start_i),
      .valid_i     (valid_i),
      .ready_o     (ready_o),
      .lb_shift_o  (lb_shift_o),
      .col_o       (col_o),
      .row_o       (row_o),
      .valid_o     (valid_o),
      .ready_i     (ready_i),
      .ctr_col_o   (ctr_col_o),
      .ctr_row_o   (ctr_row_o),
      .eol_o       (eol_o),
      .eof_o       (eof_o),
      .busy_o      (busy_o),
      .frame_done_o(frame_done_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      int c;
      int r;
      int eol;
      int eof;
   } win_t;

   win_t exp_q[$];
   int   n_checks = 0;
   int   n_errors = 0;
   int   n_acc    = 0;      // pixels accepted in the current frame
   bit   model_idle = 1'b1;
   bit   exp_fd   = 1'b0;
   bit   hold_prev = 1'b0;
   int   prev_cc, prev_cr, prev_eol, prev_eof;
   int   seen     = 0;
   int   fd_cnt   = 0;
   int   cyc      = 0;

   task automatic chk(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // One clock cycle: inputs already driven; check at negedge, then advance.
   task automatic tick();
      bit   exp_rdy, acc, fd_nxt;
      int   c, r;
      win_t w;
      @(negedge clk);
      chk("frame_done", int'(frame_done_o), int'(exp_fd));
      if (exp_fd) begin
         model_idle = 1'b1;
         n_acc      = 0;
      end
      if (frame_done_o) fd_cnt++;
      fd_nxt = !model_idle && (n_acc == NPIX) && !valid_o && !rst_i;
      chk("busy", int'(busy_o), int'(!model_idle));
      exp_rdy = !rst_i && !model_idle && (n_acc < NPIX) && (!valid_o || ready_i);
      chk("ready", int'(ready_o), int'(exp_rdy));
      chk("lb_shift", int'(lb_shift_o), int'(valid_i && exp_rdy));
      if (n_acc < NPIX) begin
         chk("col", int'(col_o), n_acc % W);
         chk("row", int'(row_o), n_acc / W);
      end
      if (hold_prev) begin
         chk("hold_valid", int'(valid_o), 1);
         chk("hold_ccol", int'(ctr_col_o), prev_cc);
         chk("hold_crow", int'(ctr_row_o), prev_cr);
         chk("hold_eol", int'(eol_o), prev_eol);
         chk("hold_eof", int'(eof_o), prev_eof);
      end
      if (valid_o && ready_i) begin
         if (exp_q.size() == 0) begin
            chk("win_extra", 1, 0);
         end else begin
            w = exp_q.pop_front();
            chk("ctr_col", int'(ctr_col_o), w.c);
            chk("ctr_row", int'(ctr_row_o), w.r);
            chk("eol", int'(eol_o), w.eol);
            chk("eof", int'(eof_o), w.eof);
            seen++;
         end
      end
      acc = valid_i && exp_rdy;
      if (acc) begin
         c = n_acc % W;
         r = n_acc / W;
         if (r >= K - 1 && c >= K - 1) begin
            w.c   = c - K / 2;
            w.r   = r - K / 2;
            w.eol = (c == W - 1) ? 1 : 0;
            w.eof = (c == W - 1 && r == H - 1) ? 1 : 0;
            exp_q.push_back(w);
         end
         n_acc++;
      end
      if (start_i && model_idle && !rst_i) model_idle = 1'b0;
      hold_prev = valid_o && !ready_i;
      prev_cc  = int'(ctr_col_o);
      prev_cr  = int'(ctr_row_o);
      prev_eol = int'(eol_o);
      prev_eof = int'(eof_o);
      if (rst_i) begin
         model_idle = 1'b1;
         n_acc      = 0;
         exp_q.delete();
         hold_prev  = 1'b0;
         fd_nxt     = 1'b0;
      end
      exp_fd = fd_nxt;
      cyc++;
      @(posedge clk);
      #1;
   endtask

   // vmode: 0 always valid, 1 toggle, 2 random. rmode: 0 always ready,
   // 1 stall 5 cycles on first window, 2 random.
   task automatic run_frame(input int vmode, input int rmode, input int abort_at,
                            input bit start_in_stream);
      int  stall = 0;
      bit  done  = 1'b0;
      seen   = 0;
      fd_cnt = 0;
      start_i = 1'b1;
      valid_i = 1'b1;
      ready_i = 1'b1;
      tick();
      start_i = 1'b0;
      for (int i = 0; i < 400 && !done; i++) begin
         case (vmode)
            0:       valid_i = 1'b1;
            1:       valid_i = (i % 2 == 0);
            default: valid_i = ($urandom_range(0, 3) != 0);
         endcase
         case (rmode)
            1: begin
               if (valid_o && stall < 5) begin
                  ready_i = 1'b0;
                  stall++;
               end else begin
                  ready_i = 1'b1;
               end
            end
            2:       ready_i = ($urandom_range(0, 2) != 0);
            default: ready_i = 1'b1;
         endcase
         start_i = start_in_stream && (n_acc >= 2 * W) && (n_acc < NPIX);
         if (abort_at > 0 && n_acc == abort_at) begin
            rst_i = 1'b1;
            tick();
            rst_i   = 1'b0;
            valid_i = 1'b1;
            for (int j = 0; j < 4; j++) tick();
            chk("abort_fd", fd_cnt, 0);
            chk("abort_valid", int'(valid_o), 0);
            return;
         end
         tick();
         if (fd_cnt == 1) done = 1'b1;
      end
      chk("frame_timeout", int'(done), 1);
      start_i = 1'b0;
      valid_i = 1'b1;
      ready_i = 1'b1;
      tick();
      tick();
      chk("fd_count", fd_cnt, 1);
      chk("windows", seen, 2);
      chk("queue_left", exp_q.size(), 0);
      chk("idle_busy", int'(busy_o), 0);
   endtask

   initial begin
      rst_i   = 1'b1;
      valid_i = 1'b1;
      @(posedge clk);
      #1;
      tick();
      rst_i = 1'b0;
      // Idle with valid_i high and no start: nothing may be accepted.
      for (int i = 0; i < 3; i++) tick();
      chk("idle_valid_o", int'(valid_o), 0);

      run_frame(0, 0, 0, 1'b0);   // back-to-back frame
      run_frame(0, 1, 0, 1'b0);   // downstream stall at first window
      run_frame(1, 0, 0, 1'b0);   // toggled valid during fill
      run_frame(0, 0, 6, 1'b0);   // reset after 6 accepts
      run_frame(0, 0, 0, 1'b0);   // fresh frame after abort
      run_frame(0, 0, 0, 1'b1);   // start_i held during stream
      for (int f = 0; f < 4; f++) run_frame(2, 2, 0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
